// File: rtl/alu_mc_pkg.sv
// Shared types for the multi-cycle ALU: opcode encoding and control FSM states.
// No logic, so no latency.
// No handshake, so no backpressure.
package alu_mc_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_AND  = 4'd1,
    OP_OR   = 4'd2,
    OP_SLL  = 4'd3,
    OP_SLT  = 4'd4,
    OP_SRL  = 4'd5,
    OP_SUB  = 4'd6,
    OP_XOR  = 4'd7,
    OP_BEQ  = 4'd8,
    OP_BNE  = 4'd9,
    OP_SRA  = 4'd10,
    OP_SLTU = 4'd11,
    OP_MUL  = 4'd12
  } alu_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_mc_mul.sv
// Iterative shift-add multiplier producing the low WIDTH bits of a*b. One multiplier bit per cycle.
// Latency: start pulse loads the operands, then WIDTH iteration cycles. done is high during the last cycle, with product valid combinationally.
// Backpressure: none. The caller must capture product while done is high.
module alu_mc_mul #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic             run_q, run_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] acc_nxt;

  // Partial-product accumulation for the current multiplier bit.
  always_comb begin
    acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  // Iteration control: load on start, otherwise shift one bit per cycle until the last bit.
  always_comb begin
    run_d    = run_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (start) begin
      run_d    = 1'b1;
      cnt_d    = '0;
      mcand_d  = a;
      mplier_d = b;
      acc_d    = '0;
    end else if (run_q) begin
      acc_d    = acc_nxt;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
      if (cnt_q == LAST) begin
        run_d = 1'b0;
      end
    end
  end

  // State registers. Reset aborts any iteration in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q    <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      run_q    <= run_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

  // The final iteration's sum is handed out directly, saving one cycle.
  assign done    = run_q && (cnt_q == LAST);
  assign product = acc_nxt;

endmodule

// File: rtl/alu_mc.sv
// ALU with registered result and valid/ready handshake. Optional iterative MUL is built in when ALU_MC_MUL_EN is defined.
// Latency: 1 cycle for all ops except MUL, which takes WIDTH+1 cycles when enabled.
// Backpressure: out_valid && !out_ready holds the result and blocks acceptance. Drain and accept may coincide.
module alu_mc #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  import alu_mc_pkg::*;

  logic               accept;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_zero;
  logic               out_valid_q, out_valid_d;
  logic               zero_q, zero_d;
  logic [WIDTH-1:0]   result_q, result_d;

  assign shamt = b[SHAMT_W-1:0];

`ifdef ALU_MC_MUL_EN
  state_t           state_q, state_d;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  alu_mc_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product)
  );

  assign busy     = (state_q == ST_MUL);
  assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
`else
  assign busy     = 1'b0;
  assign in_ready = !out_valid_q || out_ready;
`endif

  assign accept = in_valid && in_ready;

  // Single-cycle datapath. MUL and illegal codes produce zero here.
  always_comb begin
    alu_res  = '0;
    alu_zero = 1'b0;
    case (op)
      OP_ADD:  alu_res = a + b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_SLL:  alu_res = a << shamt;
      OP_SLT:  alu_res = WIDTH'($signed(a) < $signed(b));
      OP_SRL:  alu_res = a >> shamt;
      OP_SUB:  alu_res = a - b;
      OP_XOR:  alu_res = a ^ b;
      OP_BEQ:  alu_zero = (a == b);
      OP_BNE:  alu_zero = (a != b);
      OP_SRA:  alu_res = $signed(a) >>> shamt;
      OP_SLTU: alu_res = WIDTH'(a < b);
      default: ;
    endcase
  end

  // Output register and FSM next state: drain on out_ready, load on accept or on multiplier completion.
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
`ifdef ALU_MC_MUL_EN
    state_d   = state_q;
    mul_start = 1'b0;
    if (accept && (op == OP_MUL)) begin
      mul_start = 1'b1;
      state_d   = ST_MUL;
    end else if (accept) begin
      result_d    = alu_res;
      zero_d      = alu_zero;
      out_valid_d = 1'b1;
    end
    if ((state_q == ST_MUL) && mul_done) begin
      result_d    = mul_product;
      zero_d      = 1'b0;
      out_valid_d = 1'b1;
      state_d     = ST_IDLE;
    end
`else
    if (accept) begin
      result_d    = alu_res;
      zero_d      = alu_zero;
      out_valid_d = 1'b1;
    end
`endif
  end

  // Result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
    end
  end

`ifdef ALU_MC_MUL_EN
  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end
`endif

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=32): directed cases, randomized ops against a behavioural model.
// Stimulus and checks are applied on the falling clock edge.
// Covers the handshake under backpressure, and MUL timing and mid-operation reset when ALU_MC_MUL_EN is defined.
module tb_alu_mc;

  localparam int WIDTH = 32;
`ifdef ALU_MC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour written directly from the opcode table.
  task automatic model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] r, output logic z);
    int unsigned sh;
    sh = y % 32;
    r  = 32'd0;
    z  = 1'b0;
    case (o)
      4'd0:  r = x + y;
      4'd1:  r = x & y;
      4'd2:  r = x | y;
      4'd3:  r = x << sh;
      4'd4:  r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd5:  r = x >> sh;
      4'd6:  r = x - y;
      4'd7:  r = x ^ y;
      4'd8:  z = (x == y);
      4'd9:  z = (x != y);
      4'd10: r = $signed(x) >>> sh;
      4'd11: r = (x < y) ? 32'd1 : 32'd0;
      4'd12: if (MUL_EN) r = x * y;
      default: r = 32'd0;
    endcase
  endtask

  // Issue one request at a falling edge (out_ready high), wait for its result, check latency and value.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] er;
    logic        ez;
    int          lat;
    int          exp_lat;
    model(o, x, y, er, ez);
    exp_lat = (MUL_EN && o == 4'd12) ? WIDTH + 1 : 1;
    check({tag, "_in_ready"}, in_ready, 1);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_result"}, result, er);
    check({tag, "_zero"}, zero, ez);
  endtask

  logic [31:0] exp_r [10];
  logic        exp_z [10];
  logic [3:0]  rop;
  int          seen;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = 4'd0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_zero", zero, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);

    // Directed single-cycle cases
    run_op("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1);
    run_op("sra", 4'd10, 32'h8000_0000, 32'h24);
    run_op("srl", 4'd5, 32'h8000_0000, 32'h24);
    run_op("sll", 4'd3, 32'h0000_0F0F, 32'hFFFF_FFE8);
    run_op("slt", 4'd4, 32'hFFFF_FFFF, 32'd1);
    run_op("sltu", 4'd11, 32'hFFFF_FFFF, 32'd1);
    run_op("beq", 4'd8, 32'd5, 32'd5);
    run_op("bne", 4'd9, 32'd5, 32'd5);
    run_op("sub", 4'd6, 32'd3, 32'd5);
    run_op("illegal", 4'd14, 32'h1234_5678, 32'h9ABC_DEF0);
    run_op("op12", 4'd12, 32'd3, 32'd4);

    // Back-to-back: one result per cycle
    for (int i = 0; i < 10; i++) begin
      rop = 4'($urandom_range(0, 15));
      if (rop == 4'd12) rop = 4'd7;
      op = rop; a = $urandom; b = $urandom;
      if (i % 3 == 0) b = a;
      model(op, a, b, exp_r[i], exp_z[i]);
      in_valid = 1'b1;
      @(negedge clk);
      check("b2b_valid", out_valid, 1);
      check("b2b_result", result, exp_r[i]);
      check("b2b_zero", zero, exp_z[i]);
    end
    in_valid = 1'b0;
    @(negedge clk);

    // Backpressure: hold XOR result, ignore pending request, then drain and accept on one edge
    out_ready = 1'b0;
    op = 4'd7; a = 32'hF0; b = 32'hFF; in_valid = 1'b1;
    @(negedge clk);
    op = 4'd0; a = 32'd2; b = 32'd3;
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", out_valid, 1);
      check("bp_result", result, 32'h0F);
      check("bp_in_ready", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_new_valid", out_valid, 1);
    check("bp_new_result", result, 32'd5);

`ifdef ALU_MC_MUL_EN
    // MUL timing; changing inputs while busy must not disturb it
    op = 4'd12; a = 32'd7; b = 32'd6; in_valid = 1'b1;
    @(negedge clk);
    op = 4'd0;
    for (int k = 0; k < 32; k++) begin
      check("mul_busy", busy, 1);
      check("mul_in_ready", in_ready, 0);
      check("mul_out_valid", out_valid, 0);
      a = $urandom; b = $urandom;
      if (k == 31) in_valid = 1'b0;
      @(negedge clk);
    end
    check("mul_done_valid", out_valid, 1);
    check("mul_done_result", result, 32'd42);
    check("mul_done_busy", busy, 0);
    @(negedge clk);
    run_op("mul_wrap", 4'd12, 32'hFFFF_FFFF, 32'd2);

    // Reset in the middle of a MUL
    op = 4'd12; a = $urandom; b = $urandom; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mulrst_out_valid", out_valid, 0);
    check("mulrst_busy", busy, 0);
    check("mulrst_result", result, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("mulrst_no_result", seen, 0);
`endif

    run_op("post_add", 4'd0, 32'd2, 32'd3);

    // Randomized ops across the whole opcode space
    for (int i = 0; i < 20; i++) begin
      rop = 4'($urandom_range(0, 15));
      run_op("rand", rop, $urandom, (i % 4 == 0) ? 32'd9 : $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
